// File: rtl/ram_capture_buffer.sv
// Capture RAM fed by the RAM-write control FSM: fills at an auto-incrementing address,
// flags full, then streams the frame out in address order over a valid/ready port.
module ram_capture_buffer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_write_ena,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_write_full,
  input  logic              i_rd_start,
  input  logic              i_rd_ready,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_done,
  input  logic              i_clear
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    StFill,
    StFull,
    StDump
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              fetch_done_q, fetch_done_d;

  // Two-stage read pipe: s1 is the RAM read register, out is the port register.
  logic              s1_valid_q, s1_valid_d;
  logic              s1_last_q, s1_last_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_rdata_q;
  logic              mem_we;
  logic              mem_re;

  logic out_xfer;
  logic out_free;
  logic s1_free;

  assign out_xfer = out_valid_q & i_rd_ready;
  assign out_free = ~out_valid_q | i_rd_ready;
  assign s1_free  = ~s1_valid_q | out_free;

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    fetch_done_d = fetch_done_q;
    s1_valid_d   = s1_valid_q;
    s1_last_d    = s1_last_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_data_d   = out_data_q;
    done_d       = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;

    if (i_clear) begin
      state_d      = StFill;
      wr_addr_d    = '0;
      rd_addr_d    = '0;
      fetch_done_d = 1'b0;
      s1_valid_d   = 1'b0;
      s1_last_d    = 1'b0;
      out_valid_d  = 1'b0;
      out_last_d   = 1'b0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (i_write_ena) begin
            mem_we    = 1'b1;
            wr_addr_d = wr_addr_q + ADDR_W'(1);
            if (wr_addr_q == LastAddr) begin
              state_d = StFull;
            end
          end
        end
        StFull: begin
          if (i_rd_start) begin
            state_d      = StDump;
            rd_addr_d    = '0;
            fetch_done_d = 1'b0;
          end
        end
        StDump: begin
          if (out_free) begin
            out_valid_d = s1_valid_q;
            out_last_d  = s1_last_q;
            if (s1_valid_q) begin
              out_data_d = ram_rdata_q;
            end
          end
          // Refill s1 whenever it empties this cycle so ready=1 gives no bubbles.
          if (s1_free) begin
            s1_valid_d = ~fetch_done_q;
            s1_last_d  = (rd_addr_q == LastAddr);
            if (!fetch_done_q) begin
              mem_re       = 1'b1;
              rd_addr_d    = rd_addr_q + ADDR_W'(1);
              fetch_done_d = (rd_addr_q == LastAddr);
            end
          end
          if (out_xfer && out_last_q) begin
            state_d = StFull;
            done_d  = 1'b1;
          end
        end
        default: state_d = StFill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q      <= StFill;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      fetch_done_q <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      fetch_done_q <= fetch_done_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      done_q       <= done_d;
    end
  end

  // Storage is not reset; reset only blocks a write in the same cycle.
  always_ff @(posedge clk) begin
    if (mem_we && !i_rst) begin
      mem[wr_addr_q] <= i_data;
    end
    if (mem_re) begin
      ram_rdata_q <= mem[rd_addr_q];
    end
  end

  assign o_write_full = (state_q != StFill);
  assign o_rd_valid   = out_valid_q;
  assign o_rd_data    = out_data_q;
  assign o_rd_done    = done_q;

endmodule

// File: tb/tb_ram_capture_buffer.sv
// Randomized self-checking bench for ram_capture_buffer (ADDR_W=3) against a frame-level model.
module tb_ram_capture_buffer;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
  localparam int          N  = 8;

  logic          clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_write_ena = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_write_full;
  logic          i_rd_start = 1'b0;
  logic          i_rd_ready = 1'b0;
  logic          o_rd_valid;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_done;
  logic          i_clear = 1'b0;

  ram_capture_buffer #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_write_ena  (i_write_ena),
    .i_data       (i_data),
    .o_write_full (o_write_full),
    .i_rd_start   (i_rd_start),
    .i_rd_ready   (i_rd_ready),
    .o_rd_valid   (o_rd_valid),
    .o_rd_data    (o_rd_data),
    .o_rd_done    (o_rd_done),
    .i_clear      (i_clear)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: captured frame plus count of accepted writes in the current frame.
  logic [DW-1:0] model_mem [N];
  int            wcnt = 0;
  logic          model_full = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_write_ena = 1'b0;
    i_rd_start = 1'b0;
    i_clear = 1'b0;
    step();
    i_rst = 1'b0;
    model_full = 1'b0;
    wcnt = 0;
    check("rst_full", 32'(o_write_full), 32'd0);
    check("rst_valid", 32'(o_rd_valid), 32'd0);
    check("rst_done", 32'(o_rd_done), 32'd0);
    check("rst_data", 32'(o_rd_data), 32'd0);
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    model_full = 1'b0;
    wcnt = 0;
    check("clr_full", 32'(o_write_full), 32'd0);
  endtask

  task automatic wr(input logic ena, input logic [DW-1:0] d);
    i_write_ena = ena;
    i_data = d;
    step();
    i_write_ena = 1'b0;
    if (ena && !model_full) begin
      model_mem[wcnt] = d;
      wcnt++;
      if (wcnt == N) begin
        model_full = 1'b1;
        wcnt = 0;
      end
    end
    check("write_full", 32'(o_write_full), 32'(model_full));
  endtask

  // mode 0: ready held high; 1: random ready; 2: ready low 3 cycles while word 3 valid.
  // abort_at < N asserts i_clear once that many words have transferred.
  task automatic dump(input int mode, input int abort_at);
    int            idx;
    int            e;
    int            stalls;
    logic          hold;
    logic          rdy;
    logic [DW-1:0] held;
    idx = 0;
    stalls = 0;
    hold = 1'b0;
    held = '0;
    i_rd_start = 1'b1;
    i_rd_ready = 1'b1;
    step();
    i_rd_start = 1'b0;
    check("start_valid_n", 32'(o_rd_valid), 32'd0);
    step();
    check("start_valid_n1", 32'(o_rd_valid), 32'd0);
    step();
    check("first_valid", 32'(o_rd_valid), 32'd1);
    e = 2;
    while (idx < N && e < 200) begin
      if (idx == abort_at) begin
        i_clear = 1'b1;
        i_rd_ready = 1'b0;
        step();
        i_clear = 1'b0;
        model_full = 1'b0;
        wcnt = 0;
        check("clear_valid", 32'(o_rd_valid), 32'd0);
        check("clear_full", 32'(o_write_full), 32'd0);
        check("clear_done", 32'(o_rd_done), 32'd0);
        for (int i = 0; i < 3; i++) begin
          i_rd_ready = 1'b1;
          step();
          check("clear_nodone", 32'(o_rd_done), 32'd0);
          check("clear_novalid", 32'(o_rd_valid), 32'd0);
        end
        return;
      end
      if (hold) begin
        check("hold_valid", 32'(o_rd_valid), 32'd1);
        check("hold_data", 32'(o_rd_data), 32'(held));
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = !(idx == 3 && o_rd_valid && stalls < 3);
      endcase
      i_rd_ready = rdy;
      if (o_rd_valid && rdy) begin
        check("dump_data", 32'(o_rd_data), 32'(model_mem[idx]));
        idx++;
      end else if (o_rd_valid) begin
        stalls++;
      end
      hold = o_rd_valid && !rdy;
      held = o_rd_data;
      step();
      e++;
      if (idx < N) check("no_early_done", 32'(o_rd_done), 32'd0);
    end
    check("dump_words", 32'(idx), 32'(N));
    check("dump_edges", 32'(e), 32'(N + 2 + stalls));
    check("done_pulse", 32'(o_rd_done), 32'd1);
    check("done_valid", 32'(o_rd_valid), 32'd0);
    if (mode == 2) check("stall_cycles", 32'(stalls), 32'd3);
    i_rd_ready = 1'b1;
    step();
    check("done_once", 32'(o_rd_done), 32'd0);
    check("after_full", 32'(o_write_full), 32'd1);
  endtask

  task automatic random_fill();
    int guard;
    guard = 0;
    while (!model_full && guard < 100) begin
      wr(1'($urandom_range(0, 1)), 16'($urandom));
      guard++;
    end
    check("fill_reached", 32'(model_full), 32'd1);
  endtask

  initial begin
    do_reset();

    // Fill with 0x0010..0x0017, then an ignored strobe while full.
    for (int i = 0; i < N; i++) wr(1'b1, 16'(16'h0010 + i));
    wr(1'b1, 16'hDEAD);
    dump(0, N);
    dump(2, N);

    // Repeat dump aborted by clear after 4 words.
    dump(1, 4);

    // Gapped writes: only the even cycles strobe.
    for (int i = 0; i < 16; i++) wr(1'(i % 2 == 0), 16'(16'h0100 + i));
    dump(1, N);

    // Start pulse while filling is ignored.
    do_clear();
    i_rd_start = 1'b1;
    step();
    i_rd_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("fill_start_valid", 32'(o_rd_valid), 32'd0);
      step();
    end
    check("fill_start_full", 32'(o_write_full), 32'd0);

    // Reset after 5 writes; a fresh frame of 8 writes is then needed.
    for (int i = 0; i < 5; i++) wr(1'b1, 16'($urandom));
    do_reset();
    for (int i = 0; i < N; i++) wr(1'b1, 16'(16'h0200 + i));
    dump(0, N);

    // Randomized frames.
    for (int r = 0; r < 4; r++) begin
      do_clear();
      random_fill();
      wr(1'b1, 16'($urandom));
      dump(1, N);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
